// File: rtl/mbus_tx_msg_sequencer_pkg.sv
// Shared bus widths and FSM state type for the MBus TX message sequencer.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mbus_tx_msg_sequencer_pkg;
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_ACK_LO    = 3'd2,
        ST_WAIT_RESP = 3'd3,
        ST_RESP_LO   = 3'd4
    } seq_state_e;
endpackage

// File: rtl/mbus_tx_word_fifo.sv
// Synchronous word FIFO holding one outbound message; flush drops everything queued.
module mbus_tx_word_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int DW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    output logic [DW-1:0]    head,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);
    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == PTR_W'(0) + (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mbus_tx_msg_sequencer.sv
// Buffers a message and plays it out on the MBus TX port with TX_PEND chaining and response handshake.
module mbus_tx_msg_sequencer
    import mbus_tx_msg_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic                   CLK,
    input  logic                   RESETn,
    input  logic [`ADDR_WIDTH-1:0] MSG_ADDR,
    input  logic                   MSG_PRIORITY,
    input  logic [`DATA_WIDTH-1:0] WR_DATA,
    input  logic                   WR_EN,
    input  logic                   START,
    output logic [PTR_W:0]         COUNT,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic                   WR_ERR,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   FAIL,
    output logic [`ADDR_WIDTH-1:0] TX_ADDR,
    output logic [`DATA_WIDTH-1:0] TX_DATA,
    output logic                   TX_PEND,
    output logic                   TX_REQ,
    output logic                   PRIORITY,
    input  logic                   TX_ACK,
    input  logic                   TX_SUCC,
    input  logic                   TX_FAIL,
    output logic                   TX_RESP_ACK
);
    seq_state_e state, state_d;
    logic [`ADDR_WIDTH-1:0] addr_d;
    logic [`DATA_WIDTH-1:0] data_d, head, head_eff;
    logic [PTR_W:0]         count_eff;
    logic pend_d, req_d, prio_d, resp_ack_d, busy_d, done_d, fail_d, wr_err_d;
    logic push, pop, flush, early_fail;

    assign push = WR_EN && (state == ST_IDLE) && !FULL;

    mbus_tx_word_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DW(`DATA_WIDTH)) u_fifo (
        .clk(CLK), .rst_n(RESETn), .flush(flush),
        .push(push), .push_data(WR_DATA), .pop(pop),
        .head(head), .count(COUNT), .full(FULL), .empty(EMPTY)
    );

    // A write in the START cycle is counted; on an empty FIFO it becomes the head directly.
    assign count_eff  = COUNT + (PTR_W+1)'(push);
    assign head_eff   = (COUNT == '0) ? WR_DATA : head;
    assign early_fail = TX_FAIL || (TX_SUCC && TX_PEND);

    always_comb begin
        state_d    = state;
        addr_d     = TX_ADDR;
        data_d     = TX_DATA;
        pend_d     = TX_PEND;
        req_d      = TX_REQ;
        prio_d     = PRIORITY;
        resp_ack_d = TX_RESP_ACK;
        busy_d     = BUSY;
        done_d     = 1'b0;
        fail_d     = FAIL;
        wr_err_d   = WR_ERR;
        pop        = 1'b0;
        flush      = 1'b0;
        case (state)
            ST_IDLE: if (START && count_eff != '0) begin
                addr_d   = MSG_ADDR;
                prio_d   = MSG_PRIORITY;
                data_d   = head_eff;
                pend_d   = (count_eff > 1);
                fail_d   = 1'b0;
                wr_err_d = 1'b0;
                busy_d   = 1'b1;
                req_d    = 1'b1;
                state_d  = ST_REQ;
            end
            ST_REQ, ST_ACK_LO: if (early_fail) begin
                req_d      = 1'b0;
                flush      = 1'b1;
                fail_d     = 1'b1;
                resp_ack_d = 1'b1;
                state_d    = ST_RESP_LO;
            end else if (state == ST_REQ) begin
                if (TX_ACK) begin
                    pop     = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_ACK_LO;
                end
            end else if (!TX_ACK) begin
                if (TX_PEND) begin
                    data_d  = head;
                    pend_d  = (COUNT > 1);
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: if (TX_SUCC || TX_FAIL) begin
                fail_d     = TX_FAIL;
                resp_ack_d = 1'b1;
                state_d    = ST_RESP_LO;
            end
            ST_RESP_LO: if (!TX_SUCC && !TX_FAIL) begin
                resp_ack_d = 1'b0;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A dropped write outranks the clear from a coincident START.
        if (WR_EN && !push) wr_err_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state       <= ST_IDLE;
            TX_ADDR     <= '0;
            TX_DATA     <= '0;
            TX_PEND     <= 1'b0;
            TX_REQ      <= 1'b0;
            PRIORITY    <= 1'b0;
            TX_RESP_ACK <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            FAIL        <= 1'b0;
            WR_ERR      <= 1'b0;
        end else begin
            state       <= state_d;
            TX_ADDR     <= addr_d;
            TX_DATA     <= data_d;
            TX_PEND     <= pend_d;
            TX_REQ      <= req_d;
            PRIORITY    <= prio_d;
            TX_RESP_ACK <= resp_ack_d;
            BUSY        <= busy_d;
            DONE        <= done_d;
            FAIL        <= fail_d;
            WR_ERR      <= wr_err_d;
        end
    end
endmodule

// File: tb/tb_mbus_tx_msg_sequencer.sv
// Directed scenario bench for the MBus TX message sequencer with a hand-driven bus.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mbus_tx_msg_sequencer;
    logic                   CLK = 0, RESETn = 0;
    logic [`ADDR_WIDTH-1:0] MSG_ADDR = '0;
    logic                   MSG_PRIORITY = 0;
    logic [`DATA_WIDTH-1:0] WR_DATA = '0;
    logic                   WR_EN = 0, START = 0;
    logic [3:0]             COUNT;
    logic                   FULL, EMPTY, WR_ERR, BUSY, DONE, FAIL;
    logic [`ADDR_WIDTH-1:0] TX_ADDR;
    logic [`DATA_WIDTH-1:0] TX_DATA;
    logic                   TX_PEND, TX_REQ, PRIORITY, TX_RESP_ACK;
    logic                   TX_ACK = 0, TX_SUCC = 0, TX_FAIL = 0;
    int n_cmp = 0, n_err = 0;

    mbus_tx_msg_sequencer #(.DEPTH(8), .PTR_W(3)) dut (
        .CLK(CLK), .RESETn(RESETn), .MSG_ADDR(MSG_ADDR), .MSG_PRIORITY(MSG_PRIORITY),
        .WR_DATA(WR_DATA), .WR_EN(WR_EN), .START(START), .COUNT(COUNT), .FULL(FULL),
        .EMPTY(EMPTY), .WR_ERR(WR_ERR), .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL),
        .TX_ADDR(TX_ADDR), .TX_DATA(TX_DATA), .TX_PEND(TX_PEND), .TX_REQ(TX_REQ),
        .PRIORITY(PRIORITY), .TX_ACK(TX_ACK), .TX_SUCC(TX_SUCC), .TX_FAIL(TX_FAIL),
        .TX_RESP_ACK(TX_RESP_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        WR_DATA = d; WR_EN = 1; tick(); WR_EN = 0;
    endtask

    task automatic launch(input logic [31:0] a, input logic p);
        MSG_ADDR = a; MSG_PRIORITY = p; START = 1; tick(); START = 0;
    endtask

    // Serves one word: waits for TX_REQ, holds it two cycles, then ACKs and releases.
    task automatic bus_word(output logic [31:0] d, output logic p, output bit ok, output bit stable);
        ok = 0; stable = 1; d = '0; p = 0;
        for (int i = 0; i < 50 && !ok; i++) if (TX_REQ) ok = 1; else tick();
        if (!ok) return;
        d = TX_DATA; p = TX_PEND;
        repeat (2) begin
            tick();
            if (TX_REQ !== 1'b1 || TX_DATA !== d || TX_PEND !== p) stable = 0;
        end
        TX_ACK = 1; tick();
        if (TX_REQ !== 1'b0) stable = 0;
        TX_ACK = 0; tick();
    endtask

    // Response handshake; reports RESP_ACK seen, DONE on release cycle and DONE gone next cycle.
    task automatic bus_resp(input logic fail, output bit ack_ok, output bit done_ok, output bit done_clr);
        ack_ok = 0;
        if (fail) TX_FAIL = 1; else TX_SUCC = 1;
        for (int i = 0; i < 20 && !ack_ok; i++) begin tick(); if (TX_RESP_ACK === 1'b1) ack_ok = 1; end
        TX_SUCC = 0; TX_FAIL = 0; tick();
        done_ok = (DONE === 1'b1) && (TX_RESP_ACK === 1'b0) && (BUSY === 1'b0);
        tick();
        done_clr = (DONE === 1'b0);
    endtask

    task automatic test_reset();
        RESETn = 0; tick(); tick();
        n_cmp++; if ({TX_REQ, BUSY, DONE, FAIL, WR_ERR, FULL, TX_RESP_ACK, TX_PEND, PRIORITY} !== 9'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 0", {TX_REQ, BUSY, DONE, FAIL, WR_ERR, FULL, TX_RESP_ACK, TX_PEND, PRIORITY}); end
        n_cmp++; if (EMPTY !== 1'b1 || COUNT !== 4'd0) begin
            n_err++; $display("FAIL reset_empty got empty=%b count=%0d want 1/0", EMPTY, COUNT); end
        n_cmp++; if (TX_DATA !== 32'h0 || TX_ADDR !== 32'h0) begin
            n_err++; $display("FAIL reset_data got %h/%h want 0/0", TX_DATA, TX_ADDR); end
        RESETn = 1; tick();
    endtask

    task automatic test_single();
        logic [31:0] d; logic p; bit ok, st, a, dn, dc;
        write_word(32'hDEADBEEF);
        n_cmp++; if (COUNT !== 4'd1) begin n_err++; $display("FAIL single_count got %0d want 1", COUNT); end
        launch(32'h12, 0);
        n_cmp++; if (TX_REQ !== 1'b1 || BUSY !== 1'b1 || TX_ADDR !== 32'h12) begin
            n_err++; $display("FAIL single_req got req=%b busy=%b addr=%h want 1/1/12", TX_REQ, BUSY, TX_ADDR); end
        bus_word(d, p, ok, st);
        n_cmp++; if (!ok || !st || d !== 32'hDEADBEEF || p !== 1'b0) begin
            n_err++; $display("FAIL single_word got ok=%0d st=%0d data=%h pend=%b want 1/1/deadbeef/0", ok, st, d, p); end
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL single_empty got %b want 1", EMPTY); end
        bus_resp(0, a, dn, dc);
        n_cmp++; if (!a || !dn || !dc || FAIL !== 1'b0) begin
            n_err++; $display("FAIL single_resp got ack=%0d done=%0d clr=%0d fail=%b want 1/1/1/0", a, dn, dc, FAIL); end
        n_cmp++; if (TX_DATA !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_hold got %h want deadbeef", TX_DATA); end
    endtask

    task automatic test_multi();
        logic [31:0] d; logic p; bit ok, st, a, dn, dc;
        for (int i = 1; i <= 3; i++) write_word(32'(i));
        n_cmp++; if (COUNT !== 4'd3) begin n_err++; $display("FAIL multi_count got %0d want 3", COUNT); end
        launch(32'hA5, 1);
        n_cmp++; if (PRIORITY !== 1'b1) begin n_err++; $display("FAIL multi_prio got %b want 1", PRIORITY); end
        WR_DATA = 32'hBAD; WR_EN = 1; tick(); WR_EN = 0;
        n_cmp++; if (WR_ERR !== 1'b1 || COUNT !== 4'd3) begin
            n_err++; $display("FAIL busy_write got err=%b count=%0d want 1/3", WR_ERR, COUNT); end
        for (int i = 0; i < 3; i++) begin
            bus_word(d, p, ok, st);
            n_cmp++; if (!ok || !st || d !== 32'(i + 1) || p !== (i < 2)) begin
                n_err++; $display("FAIL multi_word%0d got ok=%0d st=%0d data=%h pend=%b want 1/1/%h/%b", i, ok, st, d, p, i + 1, i < 2); end
            n_cmp++; if (COUNT !== 4'(2 - i)) begin n_err++; $display("FAIL multi_cnt%0d got %0d want %0d", i, COUNT, 2 - i); end
        end
        bus_resp(0, a, dn, dc);
        n_cmp++; if (!a || !dn || !dc || FAIL !== 1'b0) begin
            n_err++; $display("FAIL multi_resp got ack=%0d done=%0d clr=%0d fail=%b want 1/1/1/0", a, dn, dc, FAIL); end
    endtask

    task automatic test_early_fail();
        logic [31:0] d; logic p; bit ok, st;
        for (int i = 0; i < 4; i++) write_word(32'hA0 + 32'(i));
        launch(32'h7, 0);
        bus_word(d, p, ok, st);
        n_cmp++; if (!ok || d !== 32'hA0 || p !== 1'b1 || TX_REQ !== 1'b1 || TX_DATA !== 32'hA1) begin
            n_err++; $display("FAIL efail_w1 got ok=%0d data=%h pend=%b req=%b next=%h want 1/a0/1/1/a1", ok, d, p, TX_REQ, TX_DATA); end
        TX_FAIL = 1; TX_ACK = 1; tick(); TX_ACK = 0;
        n_cmp++; if (TX_REQ !== 1'b0 || COUNT !== 4'd0 || TX_RESP_ACK !== 1'b1 || BUSY !== 1'b1) begin
            n_err++; $display("FAIL efail_abort got req=%b count=%0d rack=%b busy=%b want 0/0/1/1", TX_REQ, COUNT, TX_RESP_ACK, BUSY); end
        TX_FAIL = 0; tick();
        n_cmp++; if (DONE !== 1'b1 || FAIL !== 1'b1 || TX_RESP_ACK !== 1'b0 || BUSY !== 1'b0) begin
            n_err++; $display("FAIL efail_done got done=%b fail=%b rack=%b busy=%b want 1/1/0/0", DONE, FAIL, TX_RESP_ACK, BUSY); end
        tick();
    endtask

    task automatic test_start_empty();
        logic saw = 0;
        launch(32'h3, 0);
        for (int i = 0; i < 4; i++) begin if (TX_REQ || BUSY || DONE) saw = 1; tick(); end
        n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL start_empty got activity=%b want 0", saw); end
        n_cmp++; if (FAIL !== 1'b1) begin n_err++; $display("FAIL fail_hold got %b want 1", FAIL); end
    endtask

    task automatic test_start_with_write();
        logic [31:0] d; logic p; bit ok, st, a, dn, dc;
        WR_DATA = 32'hC0FFEE; WR_EN = 1; launch(32'h9, 0); WR_EN = 0;
        n_cmp++; if (TX_REQ !== 1'b1 || TX_DATA !== 32'hC0FFEE || TX_PEND !== 1'b0 || FAIL !== 1'b0) begin
            n_err++; $display("FAIL start_wr got req=%b data=%h pend=%b fail=%b want 1/c0ffee/0/0", TX_REQ, TX_DATA, TX_PEND, FAIL); end
        bus_word(d, p, ok, st);
        bus_resp(1, a, dn, dc);
        n_cmp++; if (!a || !dn || FAIL !== 1'b1 || EMPTY !== 1'b1) begin
            n_err++; $display("FAIL late_fail got ack=%0d done=%0d fail=%b empty=%b want 1/1/1/1", a, dn, FAIL, EMPTY); end
    endtask

    task automatic test_overflow();
        logic [31:0] d; logic p; bit ok, st, a, dn, dc;
        for (int i = 0; i < 8; i++) write_word(32'h100 + 32'(i));
        n_cmp++; if (FULL !== 1'b1 || WR_ERR !== 1'b0) begin
            n_err++; $display("FAIL full got full=%b err=%b want 1/0", FULL, WR_ERR); end
        write_word(32'h1FF);
        n_cmp++; if (WR_ERR !== 1'b1 || COUNT !== 4'd8) begin
            n_err++; $display("FAIL overflow got err=%b count=%0d want 1/8", WR_ERR, COUNT); end
        launch(32'h44, 0);
        n_cmp++; if (WR_ERR !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", WR_ERR); end
        for (int i = 0; i < 8; i++) begin
            bus_word(d, p, ok, st);
            n_cmp++; if (!ok || !st || d !== 32'h100 + 32'(i) || p !== (i < 7)) begin
                n_err++; $display("FAIL ovf_word%0d got ok=%0d st=%0d data=%h pend=%b want 1/1/%h/%b", i, ok, st, d, p, 32'h100 + i, i < 7); end
        end
        bus_resp(0, a, dn, dc);
        n_cmp++; if (!a || !dn || !dc || FAIL !== 1'b0) begin
            n_err++; $display("FAIL ovf_resp got ack=%0d done=%0d clr=%0d fail=%b want 1/1/1/0", a, dn, dc, FAIL); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic p; bit ok, st, a, dn, dc;
        write_word(32'h11); write_word(32'h22);
        launch(32'h5, 0);
        RESETn = 0; tick();
        n_cmp++; if (TX_REQ !== 1'b0 || BUSY !== 1'b0 || EMPTY !== 1'b1) begin
            n_err++; $display("FAIL mid_reset got req=%b busy=%b empty=%b want 0/0/1", TX_REQ, BUSY, EMPTY); end
        RESETn = 1; tick();
        write_word(32'h55);
        launch(32'h6, 0);
        bus_word(d, p, ok, st);
        bus_resp(0, a, dn, dc);
        n_cmp++; if (!ok || d !== 32'h55 || p !== 1'b0 || !dn || FAIL !== 1'b0) begin
            n_err++; $display("FAIL post_reset got ok=%0d data=%h pend=%b done=%0d fail=%b want 1/55/0/1/0", ok, d, p, dn, FAIL); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_early_fail();
        test_start_empty();
        test_start_with_write();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
